// File: rtl/cordic_sqrt_issuer.sv
// cordic_sqrt_issuer: one-at-a-time initiator for the CORDIC square-root engine with timeout watchdog.
// Define CORDIC_ISSUER_STATS_EN to add saturating stat_ok/stat_timeout counters.
module cordic_sqrt_issuer #(
  parameter int DATA_W      = 18,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_x,
  input  logic [DATA_W-1:0] s_y,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_x,
  output logic [DATA_W-1:0] eng_y,
  input  logic [DATA_W-1:0] eng_sqrt,
  input  logic              eng_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_sqrt,
  output logic              m_err,
  output logic              busy
`ifdef CORDIC_ISSUER_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_ok,
  output logic [CNT_W-1:0]  stat_timeout
`endif
);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_edge, timeout;
  if (TIMEOUT_CYC < 2 || CNT_W < 1) begin : g_param_chk
    $error("cordic_sqrt_issuer: TIMEOUT_CYC must be >= 2 and CNT_W >= 1");
  end
  // Only a fresh rising edge of done completes an operation; a stale level never does.
  assign done_edge = eng_done & ~done_q;
  assign cnt_d     = &cnt_q ? cnt_q : cnt_q + CW'(1);
  assign timeout   = cnt_d == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      s_ready      <= 1'b0;
      eng_start    <= 1'b0;
      eng_x        <= '0;
      eng_y        <= '0;
      m_valid      <= 1'b0;
      m_sqrt       <= '0;
      m_err        <= 1'b0;
      busy         <= 1'b0;
`ifdef CORDIC_ISSUER_STATS_EN
      stat_ok      <= '0;
      stat_timeout <= '0;
`endif
    end else begin
      done_q <= eng_done;
      case (state_q)
        IDLE: begin
          if (s_valid && s_ready) begin
            eng_x     <= s_x;
            eng_y     <= s_y;
            eng_start <= 1'b1;
            s_ready   <= 1'b0;
            busy      <= 1'b1;
            state_q   <= ISSUE;
          end else begin
            s_ready   <= 1'b1;
          end
        end
        ISSUE: begin
          eng_start <= 1'b0;
          cnt_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (done_edge) begin
            m_sqrt  <= eng_sqrt;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
            state_q <= RESP;
`ifdef CORDIC_ISSUER_STATS_EN
            stat_ok <= &stat_ok ? stat_ok : stat_ok + CNT_W'(1);
`endif
          end else if (timeout) begin
            m_sqrt  <= '0;
            m_err   <= 1'b1;
            m_valid <= 1'b1;
            state_q <= RESP;
`ifdef CORDIC_ISSUER_STATS_EN
            stat_timeout <= &stat_timeout ? stat_timeout : stat_timeout + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_sqrt_issuer.sv
// tb_cordic_sqrt_issuer: vector table plus hand sequences, results checked through an expected-result queue.
module tb_cordic_sqrt_issuer;
  localparam int DW = 18;
  localparam int TO = 64;
  typedef struct {logic signed [DW-1:0] x, y, res; int dly;} vec_t;
  typedef struct {logic signed [DW-1:0] s; logic e;} exp_t;
  logic clk = 0, rst_n = 0;
  logic s_valid = 0, s_ready, eng_start, eng_done = 0, m_valid, m_ready = 1, m_err, busy;
  logic signed [DW-1:0] s_x = 0, s_y = 0, eng_x, eng_y, eng_sqrt = 0, m_sqrt;
  int total = 0, bad = 0, exp_ok = 0, exp_to = 0;
  exp_t q[$];
  vec_t v[6];
`ifdef CORDIC_ISSUER_STATS_EN
  logic [15:0] stat_ok, stat_timeout;
`endif
  cordic_sqrt_issuer #(.DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_sqrt(eng_sqrt), .eng_done(eng_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_sqrt(m_sqrt), .m_err(m_err), .busy(busy)
`ifdef CORDIC_ISSUER_STATS_EN
    , .stat_ok(stat_ok), .stat_timeout(stat_timeout)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input longint a, input longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && m_valid && m_ready) begin
        if (q.size() == 0) chk("sb_unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          chk("sb_sqrt", m_sqrt, e.s);
          chk("sb_err", m_err, e.e);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation hung");
  end
  // mode 0: done pulse after dly, 1: no fresh edge (timeout), 3: drop done then raise and hold it
  task automatic op(input logic signed [DW-1:0] x, y, res, input int dly, mode, bp, input bit hold);
    int n, starts;
    bit sr, unstable;
    exp_t e;
    s_x = x; s_y = y; s_valid = 1; m_ready = (bp == 0);
    n = 0;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) begin chk("accept_wait", 0, 1); s_valid = 0; return; end
    e.s = (mode == 1) ? '0 : res; e.e = (mode == 1);
    q.push_back(e);
    @(negedge clk);
    if (!hold) s_valid = 0;
    chk("eng_start_pulse", eng_start, 1);
    chk("eng_x", eng_x, x);
    chk("eng_y", eng_y, y);
    starts = 0; sr = 0;
    if (mode == 1) begin
      n = 0;
      while (!m_valid && n < 200) begin
        @(negedge clk); n++; starts += int'(eng_start); sr |= s_ready;
      end
      chk("timeout_latency", n, TO);
      exp_to++;
    end else begin
      repeat (dly) begin @(negedge clk); starts += int'(eng_start); sr |= s_ready; end
      if (mode == 3) begin eng_done = 0; @(negedge clk); end
      eng_sqrt = res; eng_done = 1;
      @(negedge clk);
      if (mode == 0) eng_done = 0;
      chk("done_to_valid_latency", m_valid, 1);
      exp_ok++;
    end
    chk("eng_x_held", eng_x, x);
    chk("eng_y_held", eng_y, y);
    if (bp > 0) begin
      unstable = 0;
      repeat (bp) begin
        @(negedge clk);
        if (m_sqrt !== e.s || m_err !== e.e || s_ready || eng_start || !m_valid) unstable = 1;
      end
      chk("backpressure_stable", unstable, 0);
      m_ready = 1;
    end
    @(negedge clk);
    chk("handshake_to_idle", {m_valid, s_ready}, 2'b01);
    chk("single_start", starts, 0);
    chk("s_ready_low_busy", sr, 0);
`ifdef CORDIC_ISSUER_STATS_EN
    chk("stat_ok", stat_ok, exp_ok);
    chk("stat_timeout", stat_timeout, exp_to);
`endif
  endtask
  initial begin
    int n;
    bit f;
    v[0] = '{x: 300, y: 400, res: 500, dly: 20};
    v[1] = '{x: 1000, y: 0, res: 1000, dly: 1};
    v[2] = '{x: 1000, y: 1000, res: 1414, dly: 3};
    v[3] = '{x: -359, y: 510, res: 623, dly: 2};
    v[4] = '{x: -131072, y: 131071, res: -131072, dly: 7};
    v[5] = '{x: 0, y: 0, res: 0, dly: 1};
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_outputs", {eng_start, m_valid, m_err, busy}, 0);
    chk("rst_data", {eng_x, eng_y, m_sqrt}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 1);
    for (int i = 0; i < 6; i++) op(v[i].x, v[i].y, v[i].res, v[i].dly, 0, 0, 0);
    // back-to-back with s_valid held high
    op(1000, 0, 1000, 4, 0, 0, 1);
    op(1000, 1000, 1414, 2, 0, 0, 1);
    op(-359, 510, 623, 5, 0, 0, 1);
    s_valid = 0;
    op(300, 400, 500, 6, 0, 10, 0);
    op(11, 22, 0, 0, 1, 0, 0);
    eng_done = 1; @(negedge clk); eng_done = 0;
    f = 0;
    repeat (4) begin @(negedge clk); f |= m_valid | busy; end
    chk("late_done_ignored", f, 0);
    // level done left high from the previous op
    eng_done = 1; @(negedge clk);
    op(7, 8, 0, 0, 1, 0, 0);
    op(9, 10, 77, 3, 3, 0, 0);
    eng_done = 0;
    // reset in WAIT
    s_x = 5; s_y = 6; s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    repeat (5) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    rst_n = 0;
    #1;
    chk("async_rst_ctrl", {s_ready, eng_start, m_valid, m_err, busy}, 0);
    chk("async_rst_data", {eng_x, eng_y, m_sqrt}, 0);
    exp_ok = 0; exp_to = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    f = 0; n = 0;
    repeat (80) begin
      @(negedge clk); n++;
      eng_done = (n == 10);
      f |= m_valid;
    end
    eng_done = 0;
    chk("no_output_after_reset", f, 0);
    op(0, 0, 0, 4, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
